// File: rtl/write_decoder.sv
// write_decoder: register-file write-port decoder.
// Turns a destination register number into a registered one-hot load-enable
// vector, one bit per register. Output appears one clock after the inputs are
// sampled; there is no combinational input-to-output path.
//
// Optional feature macro: WRITE_DECODER_COUNT_EN
//   When defined, adds a 32-bit write_count output that counts accepted
//   writes. The count wraps from 0xFFFFFFFF to 0.
//
// Ports
//   clk            in   1         rising-edge clock
//   rst            in   1         synchronous active-high reset, highest priority
//   write_en       in   1         1 = decode reg_write this cycle, 0 = all enables low
//   reg_write      in   ADDR_W    destination register number
//   output_enable  out  NUM_REGS  registered one-hot write-enable vector
//   write_count    out  32        accepted-write counter (WRITE_DECODER_COUNT_EN only)
module write_decoder #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned MASK_R0  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                write_en,
  input  logic [ADDR_W-1:0]   reg_write,
`ifdef WRITE_DECODER_COUNT_EN
  output logic [31:0]         write_count,
`endif
  output logic [NUM_REGS-1:0] output_enable
);

  localparam int unsigned CNT_W = 32;

  // The input must address every enable exactly, so no wrap or out-of-range
  // handling is needed in the decode.
  if (NUM_REGS != (2 ** ADDR_W)) begin : g_bad_params
    $error("write_decoder: NUM_REGS must equal 2**ADDR_W");
  end

  logic [NUM_REGS-1:0] decoded_c;

  // Decode with optional masking of the hardwired zero register.
  always_comb begin
    decoded_c = '0;
    if (write_en) begin
      decoded_c = NUM_REGS'(1) << reg_write;
    end
    if (MASK_R0 != 0) begin
      decoded_c[0] = 1'b0;
    end
  end

  // Registered enable vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      output_enable <= '0;
    end else begin
      output_enable <= decoded_c;
    end
  end

`ifdef WRITE_DECODER_COUNT_EN
  // Counts only writes that actually enable a register (a masked r0 write
  // does not count).
  always_ff @(posedge clk) begin
    if (rst) begin
      write_count <= '0;
    end else if (write_en && (decoded_c != '0)) begin
      write_count <= write_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_write_decoder.sv
// Testbench for write_decoder: one unmasked and one r0-masked instance share
// the same stimulus. Table vectors, hand sequences for the counter, then a
// randomized phase compared against an arithmetic reference model.
module tb_write_decoder;

  logic        clk;
  logic        rst;
  logic        write_en;
  logic [4:0]  reg_write;
  logic [31:0] oe0;
  logic [31:0] oe1;
`ifdef WRITE_DECODER_COUNT_EN
  logic [31:0] cnt0;
  logic [31:0] cnt1;
`endif

  int checks;
  int failures;

  // reference model state
  logic [31:0] exp0;
  logic [31:0] exp1;
  longint      mcnt0;
  longint      mcnt1;

  write_decoder #(.ADDR_W(5), .NUM_REGS(32), .MASK_R0(0)) u_dut0 (
    .clk           (clk),
    .rst           (rst),
    .write_en      (write_en),
    .reg_write     (reg_write),
`ifdef WRITE_DECODER_COUNT_EN
    .write_count   (cnt0),
`endif
    .output_enable (oe0)
  );

  write_decoder #(.ADDR_W(5), .NUM_REGS(32), .MASK_R0(1)) u_dut1 (
    .clk           (clk),
    .rst           (rst),
    .write_en      (write_en),
    .reg_write     (reg_write),
`ifdef WRITE_DECODER_COUNT_EN
    .write_count   (cnt1),
`endif
    .output_enable (oe1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected enable vector from the rule: write_en ? 2**N : 0, r0 optionally masked.
  function automatic logic [31:0] model_dec(input logic we, input logic [4:0] rw, input bit mask);
    longint v;
    v = 0;
    if (we) begin
      v = 1;
      for (int k = 0; k < int'(rw); k++) v = v * 2;
    end
    if (mask && rw == 5'd0) v = 0;
    return 32'(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Apply inputs, clock once, advance the model, sample 1ns after the edge.
  task automatic step(input logic r, input logic we, input logic [4:0] rw);
    logic [31:0] d0;
    logic [31:0] d1;
    rst = r; write_en = we; reg_write = rw;
    d0 = model_dec(we, rw, 1'b0);
    d1 = model_dec(we, rw, 1'b1);
    @(posedge clk);
    #1;
    if (r) begin
      exp0 = '0; exp1 = '0; mcnt0 = 0; mcnt1 = 0;
    end else begin
      exp0 = d0; exp1 = d1;
      if (d0 != 0) mcnt0 = (mcnt0 + 1) % 64'h1_0000_0000;
      if (d1 != 0) mcnt1 = (mcnt1 + 1) % 64'h1_0000_0000;
    end
  endtask

  typedef struct {
    string       name;
    logic        r;
    logic        we;
    logic [4:0]  rw;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string nm, input logic r, input logic we, input logic [4:0] rw,
                         input logic [31:0] e0, input logic [31:0] e1);
    vec_t v;
    v.name = nm; v.r = r; v.we = we; v.rw = rw; v.e0 = e0; v.e1 = e1;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] held0;
    logic [31:0] held1;
    logic        r;
    logic        we;
    logic [4:0]  rw;
    checks = 0; failures = 0;
    exp0 = '0; exp1 = '0; mcnt0 = 0; mcnt1 = 0;
    rst = 1'b1; write_en = 1'b1; reg_write = 5'd7;

    // reset with write active must still hold outputs low
    add_vec("reset_a", 1'b1, 1'b1, 5'd7, 32'h0, 32'h0);
    add_vec("reset_b", 1'b1, 1'b1, 5'd7, 32'h0, 32'h0);
    // full sweep: masked instance differs only at r0
    for (int i = 0; i < 32; i++)
      add_vec($sformatf("sweep_%0d", i), 1'b0, 1'b1, 5'(i), 32'h1 << i,
              (i == 0) ? 32'h0 : (32'h1 << i));
    add_vec("sweep_end_31", 1'b0, 1'b1, 5'd31, 32'h8000_0000, 32'h8000_0000);
    add_vec("we_low", 1'b0, 1'b0, 5'd5, 32'h0, 32'h0);
    add_vec("mask_r0", 1'b0, 1'b1, 5'd0, 32'h0000_0001, 32'h0);
    add_vec("mask_r1", 1'b0, 1'b1, 5'd1, 32'h0000_0002, 32'h0000_0002);
    // reset mid-sweep, then resume
    for (int i = 10; i < 12; i++)
      add_vec($sformatf("pre_rst_%0d", i), 1'b0, 1'b1, 5'(i), 32'h1 << i, 32'h1 << i);
    add_vec("mid_rst_12", 1'b1, 1'b1, 5'd12, 32'h0, 32'h0);
    for (int i = 12; i < 16; i++)
      add_vec($sformatf("resume_%0d", i), 1'b0, 1'b1, 5'(i), 32'h1 << i, 32'h1 << i);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].we, vecs[i].rw);
      chk({vecs[i].name, "_oe"}, oe0, vecs[i].e0);
      chk({vecs[i].name, "_oe_masked"}, oe1, vecs[i].e1);
    end

`ifdef WRITE_DECODER_COUNT_EN
    // counter: full sweep from reset, idle cycle, then masked r0/r1 writes
    step(1'b1, 1'b1, 5'd7);
    chk("cnt_reset", cnt0, 32'd0);
    chk("cnt_reset_masked", cnt1, 32'd0);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 5'(i));
    chk("cnt_sweep", cnt0, 32'd32);
    chk("cnt_sweep_masked", cnt1, 32'd31);
    step(1'b0, 1'b0, 5'd5);
    chk("cnt_we_low", cnt0, 32'd32);
    step(1'b0, 1'b1, 5'd0);
    chk("cnt_r0", cnt0, 32'd33);
    chk("cnt_r0_masked", cnt1, 32'd31);
    step(1'b0, 1'b1, 5'd1);
    chk("cnt_r1_masked", cnt1, 32'd32);
`endif

    // randomized phase against the model, including a no-combinational-path probe
    step(1'b1, 1'b0, 5'd0);
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 19) == 0);
      we = ($urandom_range(0, 3) != 0);
      rw = 5'($urandom_range(0, 31));
      held0 = exp0; held1 = exp1;
      rst = r; write_en = we; reg_write = rw;
      #2;
      chk("rand_no_comb", oe0, held0);
      chk("rand_no_comb_masked", oe1, held1);
      step(r, we, rw);
      chk("rand_oe", oe0, exp0);
      chk("rand_oe_masked", oe1, exp1);
      chk("rand_onehot", 32'($countones(oe0) <= 1), 32'd1);
`ifdef WRITE_DECODER_COUNT_EN
      chk("rand_cnt", cnt0, 32'(mcnt0));
      chk("rand_cnt_masked", cnt1, 32'(mcnt1));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
